// File: rtl/nx_axi4s_pkg.sv
// rtl/nx_axi4s_pkg.sv - Nexus-over-AXI4-stream slot format shared by packer and bridge
package nx_axi4s_pkg;

  localparam int NX_MSG_WIDTH      = 31;
  localparam int NX_SLOT_WIDTH     = 32;
  localparam int NX_SLOT_VALID_BIT = 31;

  typedef struct packed {
    logic                    valid;
    logic [NX_MSG_WIDTH-1:0] msg;
  } nx_slot_t;

  function automatic nx_slot_t nx_make_slot(input logic valid, input logic [NX_MSG_WIDTH-1:0] msg);
    nx_slot_t s;
    s.valid = valid;
    s.msg   = valid ? msg : '0;
    return s;
  endfunction

endpackage

// File: rtl/nx_axi4s_packer_if.sv
// rtl/nx_axi4s_packer_if.sv - Nexus message input and AXI4-stream output bundle of the packer
interface nx_axi4s_packer_if #(
  parameter int AXI4_DATA_WIDTH = 128
);

  logic [nx_axi4s_pkg::NX_MSG_WIDTH-1:0] i_nx_data;
  logic                                  i_nx_valid;
  logic                                  o_nx_ready;
  logic                                  i_flush;
  logic [AXI4_DATA_WIDTH-1:0]            o_axi4s_tdata;
  logic                                  o_axi4s_tlast;
  logic                                  o_axi4s_tvalid;
  logic                                  i_axi4s_tready;
  logic                                  o_idle;

  modport slave (
    input  i_nx_data, i_nx_valid, i_flush, i_axi4s_tready,
    output o_nx_ready, o_axi4s_tdata, o_axi4s_tlast, o_axi4s_tvalid, o_idle
  );

  modport master (
    output i_nx_data, i_nx_valid, i_flush, i_axi4s_tready,
    input  o_nx_ready, o_axi4s_tdata, o_axi4s_tlast, o_axi4s_tvalid, o_idle
  );

endinterface

// File: rtl/nx_axi4s_packer.sv
// rtl/nx_axi4s_packer.sv - packs 31-bit Nexus messages into AXI4-stream beats
// Beats close when full, on idle timeout or on flush; one-beat output register.
module nx_axi4s_packer
  import nx_axi4s_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int TIMEOUT         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nx_axi4s_packer_if.slave bus
);

  localparam int SLOTS = AXI4_DATA_WIDTH / NX_SLOT_WIDTH;
  localparam int CW    = $clog2(SLOTS + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t       SLOTS_C   = cnt_t'(SLOTS);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [NX_MSG_WIDTH-1:0]    acc_q [SLOTS];
  cnt_t                       count_q;
  logic [7:0]                 idle_q;
  logic                       flush_pend_q;
  logic [AXI4_DATA_WIDTH-1:0] out_data_q;
  logic                       out_last_q;
  logic                       out_valid_q;

  logic [NX_MSG_WIDTH-1:0]    beat_acc [SLOTS];
  cnt_t                       beat_count;
  logic [AXI4_DATA_WIDTH-1:0] beat_data;
  logic [7:0]                 idle_d;
  logic can_take, full_hold, accept, carry;
  logic has_msgs, full, timeout_hit, pend_now, close, tlast, xfer;

  assign can_take       = !out_valid_q || bus.i_axi4s_tready;
  assign full_hold      = (count_q == SLOTS_C);
  assign bus.o_nx_ready = !i_rst && !(full_hold && !can_take);
  assign accept         = bus.i_nx_valid && bus.o_nx_ready;

  // A message arriving while a held full beat leaves starts the next accumulator.
  always_comb begin
    beat_acc   = acc_q;
    beat_count = count_q;
    carry      = 1'b0;
    if (accept) begin
      if (full_hold) begin
        carry = 1'b1;
      end else begin
        for (int k = 0; k < SLOTS; k++) begin
          if (cnt_t'(k) == count_q) beat_acc[k] = bus.i_nx_data;
        end
        beat_count = count_q + cnt_t'(1);
      end
    end
  end

  always_comb begin
    beat_data = '0;
    for (int k = 0; k < SLOTS; k++) begin
      beat_data[k*NX_SLOT_WIDTH +: NX_SLOT_WIDTH] = nx_make_slot(cnt_t'(k) < beat_count, beat_acc[k]);
    end
  end

  always_comb begin
    if (accept || beat_count == '0) idle_d = '0;
    else if (idle_q >= TIMEOUT_C)   idle_d = TIMEOUT_C;
    else                            idle_d = idle_q + 8'd1;
  end

  // Close is judged on the post-accept accumulator so full/flush/timeout beats leave next cycle.
  assign has_msgs    = (beat_count != '0);
  assign full        = (beat_count == SLOTS_C);
  assign timeout_hit = has_msgs && (idle_d == TIMEOUT_C);
  assign pend_now    = flush_pend_q || (bus.i_flush && has_msgs);
  assign close       = has_msgs && (full || timeout_hit || pend_now);
  assign tlast       = timeout_hit || pend_now;
  assign xfer        = close && can_take;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q        <= '{default: '0};
      count_q      <= '0;
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      if (xfer) begin
        out_data_q  <= beat_data;
        out_last_q  <= tlast;
        out_valid_q <= 1'b1;
      end else if (bus.i_axi4s_tready) begin
        out_valid_q <= 1'b0;
      end

      if (xfer) begin
        count_q      <= carry ? cnt_t'(1) : '0;
        idle_q       <= '0;
        flush_pend_q <= 1'b0;
      end else begin
        count_q      <= beat_count;
        idle_q       <= idle_d;
        flush_pend_q <= pend_now;
      end

      if (carry) acc_q[0] <= bus.i_nx_data;
      else       acc_q    <= beat_acc;
    end
  end

  assign bus.o_axi4s_tdata  = out_data_q;
  assign bus.o_axi4s_tlast  = out_last_q;
  assign bus.o_axi4s_tvalid = out_valid_q;
  assign bus.o_idle         = (count_q == '0) && !out_valid_q && !flush_pend_q;

endmodule

// File: tb/tb_nx_axi4s_packer.sv
// tb/tb_nx_axi4s_packer.sv - directed self-checking bench for nx_axi4s_packer
module tb_nx_axi4s_packer;

  localparam int W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_axi4s_packer_if #(.AXI4_DATA_WIDTH(W)) bus ();

  nx_axi4s_packer #(.AXI4_DATA_WIDTH(W), .TIMEOUT(16)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input logic [30:0] m0, input logic [30:0] m1,
                                        input logic [30:0] m2, input logic [30:0] m3,
                                        input int n);
    logic [W-1:0] b;
    logic [30:0]  m [4];
    b = '0;
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    for (int k = 0; k < 4; k++)
      if (k < n) b[k*32 +: 32] = {1'b1, m[k]};
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, nb, changes, low, seen;
    logic [W-1:0] held, last;
    logic held_valid;
    logic [W-1:0] got [3];
    int beat_cyc [8];

    bus.i_nx_data      = '0;
    bus.i_nx_valid     = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_axi4s_tready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", W'(bus.o_axi4s_tvalid), W'(0));
    chk("rst_tdata",  bus.o_axi4s_tdata,      W'(0));
    chk("rst_tlast",  W'(bus.o_axi4s_tlast),  W'(0));
    chk("rst_idle",   W'(bus.o_idle),         W'(1));
    chk("rst_ready",  W'(bus.o_nx_ready),     W'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", W'(bus.o_nx_ready), W'(1));
    @(negedge clk);

    // full beat
    bus.i_axi4s_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.i_nx_valid = 1'b1;
      bus.i_nx_data  = 31'(i);
      @(negedge clk);
    end
    bus.i_nx_valid = 1'b0;
    chk("full_tvalid", W'(bus.o_axi4s_tvalid), W'(1));
    chk("full_tdata",  bus.o_axi4s_tdata,      beat(31'h1, 31'h2, 31'h3, 31'h4, 4));
    chk("full_tlast",  W'(bus.o_axi4s_tlast),  W'(0));
    @(negedge clk);
    chk("full_after_tvalid", W'(bus.o_axi4s_tvalid), W'(0));
    chk("full_after_idle",   W'(bus.o_idle),         W'(1));

    // timeout
    bus.i_nx_valid = 1'b1;
    bus.i_nx_data  = 31'h7FFFFFFF;
    @(negedge clk);
    bus.i_nx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_early_tvalid", W'(bus.o_axi4s_tvalid), W'(0));
    @(negedge clk);
    chk("tmo_tvalid", W'(bus.o_axi4s_tvalid), W'(1));
    chk("tmo_tdata",  bus.o_axi4s_tdata,      W'(128'h00000000_00000000_00000000_FFFFFFFF));
    chk("tmo_tlast",  W'(bus.o_axi4s_tlast),  W'(1));
    @(negedge clk);
    chk("tmo_after_idle", W'(bus.o_idle), W'(1));

    // flush
    bus.i_nx_valid = 1'b1;
    bus.i_nx_data  = 31'hA;
    @(negedge clk);
    bus.i_nx_data  = 31'hB;
    bus.i_flush    = 1'b1;
    @(negedge clk);
    bus.i_nx_valid = 1'b0;
    bus.i_flush    = 1'b0;
    chk("flush_tvalid", W'(bus.o_axi4s_tvalid), W'(1));
    chk("flush_tdata",  bus.o_axi4s_tdata,      beat(31'hA, 31'hB, 31'h0, 31'h0, 2));
    chk("flush_tlast",  W'(bus.o_axi4s_tlast),  W'(1));
    @(negedge clk);
    chk("flush_after_idle", W'(bus.o_idle), W'(1));
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("empty_flush_idle", W'(bus.o_idle), W'(1));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_axi4s_tvalid) seen++;
    end
    chk("empty_flush_no_beat", W'(seen), W'(0));

    // backpressure
    bus.i_axi4s_tready = 1'b0;
    sent = 0; changes = 0; held = '0; held_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.i_nx_valid = (sent < 12);
      bus.i_nx_data  = 31'(sent + 1);
      #1;
      if (bus.i_nx_valid && bus.o_nx_ready) sent++;
      if (bus.o_axi4s_tvalid) begin
        if (held_valid && bus.o_axi4s_tdata !== held) changes++;
        held = bus.o_axi4s_tdata;
        held_valid = 1'b1;
      end
      @(negedge clk);
    end
    #1;
    chk("bp_accepts",  W'(sent),               W'(8));
    chk("bp_ready",    W'(bus.o_nx_ready),     W'(0));
    chk("bp_tvalid",   W'(bus.o_axi4s_tvalid), W'(1));
    chk("bp_tdata",    bus.o_axi4s_tdata,      beat(31'h1, 31'h2, 31'h3, 31'h4, 4));
    chk("bp_stable",   W'(changes),            W'(0));
    bus.i_axi4s_tready = 1'b1;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      bus.i_nx_valid = (sent < 12);
      bus.i_nx_data  = 31'(sent + 1);
      #1;
      if (bus.i_nx_valid && bus.o_nx_ready) sent++;
      if (bus.o_axi4s_tvalid) begin
        got[nb] = bus.o_axi4s_tdata;
        nb++;
      end
      @(negedge clk);
    end
    bus.i_nx_valid = 1'b0;
    chk("bp_beats", W'(nb),   W'(3));
    chk("bp_sent",  W'(sent), W'(12));
    chk("bp_beat0", got[0], beat(31'h1, 31'h2, 31'h3, 31'h4, 4));
    chk("bp_beat1", got[1], beat(31'h5, 31'h6, 31'h7, 31'h8, 4));
    chk("bp_beat2", got[2], beat(31'h9, 31'hA, 31'hB, 31'hC, 4));
    @(negedge clk);
    chk("bp_after_idle", W'(bus.o_idle), W'(1));

    // concurrent refill
    low = 0; nb = 0; last = '0;
    for (int c = 0; c < 24; c++) begin
      bus.i_nx_valid = (c < 16);
      bus.i_nx_data  = 31'(32'h40 + c);
      #1;
      if (bus.i_nx_valid && !bus.o_nx_ready) low++;
      if (bus.o_axi4s_tvalid) begin
        if (nb < 8) beat_cyc[nb] = c;
        last = bus.o_axi4s_tdata;
        nb++;
      end
      @(negedge clk);
    end
    bus.i_nx_valid = 1'b0;
    chk("refill_ready_low", W'(low), W'(0));
    chk("refill_beats",     W'(nb),  W'(4));
    chk("refill_first_cyc", W'(beat_cyc[0]), W'(4));
    chk("refill_spacing",   W'(beat_cyc[3] - beat_cyc[2]), W'(4));
    chk("refill_last",      last, beat(31'h4C, 31'h4D, 31'h4E, 31'h4F, 4));

    // reset mid-beat with a held output beat and a partial accumulator
    bus.i_axi4s_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.i_nx_valid = 1'b1;
      bus.i_nx_data  = (i < 4) ? 31'(32'h31 + i) : 31'(32'h21 + i - 4);
      @(negedge clk);
    end
    bus.i_nx_valid = 1'b0;
    chk("pre_rst_tvalid", W'(bus.o_axi4s_tvalid), W'(1));
    chk("pre_rst_idle",   W'(bus.o_idle),         W'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", W'(bus.o_axi4s_tvalid), W'(0));
    chk("mid_rst_idle",   W'(bus.o_idle),         W'(1));
    chk("mid_rst_ready",  W'(bus.o_nx_ready),     W'(0));
    chk("mid_rst_tdata",  bus.o_axi4s_tdata,      W'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.i_axi4s_tready = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.o_axi4s_tvalid) seen++;
    end
    chk("post_rst_no_beat", W'(seen),       W'(0));
    chk("post_rst_idle",    W'(bus.o_idle), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
